if_id_stage: RTL and testbench

Pipeline register between instruction fetch and decode. It captures a fetched 32-bit MIPS instruction and its PC, then splits the instruction into fields. It feeds `immediate` plus an extension-select flag directly to the downstream sign/zero-extend logic. It provides a valid/ready handshake with a one-entry skid buffer so fetch never loses an instruction under decode backpressure, and a flush input for branch/jump redirect.

---
 rtl/mips_pkg.sv | 46 ++++
 rtl/if_id_stage_if.sv | 40 ++++
 rtl/if_id_skid.sv | 82 ++++++++
 rtl/if_id_stage.sv | 49 ++++
 tb/tb_if_id_stage.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, instruction field positions and
// the payload carried from fetch to decode.
package mips_pkg;

  localparam int DATA_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int SHAMT_HI  = 10;
  localparam int SHAMT_LO  = 6;
  localparam int FUNCT_HI  = 5;
  localparam int FUNCT_LO  = 0;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;
  localparam int TARGET_HI = 25;
  localparam int TARGET_LO = 0;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc_plus4;
  } if_id_t;

  // Occupancy of the two-slot skid register, exposed for observation.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  // Logical immediates are zero-extended; everything else sign-extends.
  function automatic logic is_zero_ext_op(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Fetch-side and decode-side signals of the IF/ID stage. The stage uses the
// slave modport; the surrounding fetch/decode environment uses master.
interface if_id_stage_if #(
  parameter int DATA_W = 32
);
  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid must not depend on ready, and ready never depends
  // combinationally on the downstream ready.
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_instr;
  logic [DATA_W-1:0] in_pc;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] pc_plus4;
  logic [5:0]        opcode;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [5:0]        funct;
  logic [15:0]       immediate;
  logic [25:0]       target;
  logic              zero_ext;
  logic              is_rtype;
  mips_pkg::skid_state_e dbg_state;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, pc_plus4, opcode, rs, rt, rd, shamt, funct,
           immediate, target, zero_ext, is_rtype, dbg_state
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, pc_plus4, opcode, rs, rt, rd, shamt, funct,
           immediate, target, zero_ext, is_rtype, dbg_state
  );
endinterface

// File: rtl/if_id_skid.sv
// Two-slot valid/ready register: a main slot that drives the outputs and a
// skid slot that absorbs one extra item so the upstream ready can be registered.
module if_id_skid
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  if_id_t      in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output if_id_t      out_data,
  output skid_state_e state
);

  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  if_id_t main_q, main_d;
  if_id_t skid_q, skid_d;

  logic accept;
  logic consume;

  assign in_ready  = !skid_valid_q;
  assign accept    = in_valid && in_ready && !flush;
  assign consume   = main_valid_q && out_ready;
  assign out_valid = main_valid_q;
  assign out_data  = main_q;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush) begin
      // Data registers keep their contents; only the valid bits are dropped.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || consume) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
        if (accept) begin
          skid_d       = in_data;
          skid_valid_d = 1'b1;
        end
      end else if (accept) begin
        main_d       = in_data;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_data;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  always_comb begin
    state = SKID_EMPTY;
    if (skid_valid_q)      state = SKID_FULL;
    else if (main_valid_q) state = SKID_ONE;
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: captures instruction and PC+4 through a skid
// register, then slices the held instruction into MIPS fields.
module if_id_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  if_id_stage_if.slave bus
);

  if_id_t            in_data;
  if_id_t            main_data;
  logic [DATA_W-1:0] instr;
  logic              main_valid;

  // PC+4 is computed once at capture so the held value never changes.
  assign in_data.instr    = bus.in_instr;
  assign in_data.pc_plus4 = bus.in_pc + DATA_W'(4);

  if_id_skid u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_data),
    .out_valid (main_valid),
    .out_ready (bus.out_ready),
    .out_data  (main_data),
    .state     (bus.dbg_state)
  );

  assign instr         = main_data.instr;
  assign bus.out_valid = main_valid;
  assign bus.pc_plus4  = main_data.pc_plus4;
  assign bus.opcode    = instr[OPCODE_HI:OPCODE_LO];
  assign bus.rs        = instr[RS_HI:RS_LO];
  assign bus.rt        = instr[RT_HI:RT_LO];
  assign bus.rd        = instr[RD_HI:RD_LO];
  assign bus.shamt     = instr[SHAMT_HI:SHAMT_LO];
  assign bus.funct     = instr[FUNCT_HI:FUNCT_LO];
  assign bus.immediate = instr[IMM_HI:IMM_LO];
  assign bus.target    = instr[TARGET_HI:TARGET_LO];
  assign bus.zero_ext  = is_zero_ext_op(instr[OPCODE_HI:OPCODE_LO]);
  assign bus.is_rtype  = (instr[OPCODE_HI:OPCODE_LO] == OP_RTYPE);

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: decode vector table plus hand-written
// backpressure, flush and mid-stream reset sequences.
module tb_if_id_stage;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  if_id_stage_if bus ();

  if_id_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        zext;
    logic        rtype;
    logic [31:0] pc4;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid = v;
    bus.in_instr = instr;
    bus.in_pc    = pc;
  endtask

  function automatic logic [31:0] held_instr();
    return {bus.opcode, bus.target};
  endfunction

  initial begin
    vecs[0] = '{32'h34088000, 32'h00400000, 6'h0D, 5'd0, 5'd8,  5'd16, 5'd0,  6'h00, 16'h8000, 26'h0088000, 1'b1, 1'b0, 32'h00400004};
    vecs[1] = '{32'h2008FFFF, 32'h00400004, 6'h08, 5'd0, 5'd8,  5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h008FFFF, 1'b0, 1'b0, 32'h00400008};
    vecs[2] = '{32'h012A4020, 32'h00400008, 6'h00, 5'd9, 5'd10, 5'd8,  5'd0,  6'h20, 16'h4020, 26'h12A4020, 1'b0, 1'b1, 32'h0040000C};
    vecs[3] = '{32'h30A500FF, 32'h00400010, 6'h0C, 5'd5, 5'd5,  5'd0,  5'd3,  6'h3F, 16'h00FF, 26'h0A500FF, 1'b1, 1'b0, 32'h00400014};
    vecs[4] = '{32'h38000001, 32'h12345678, 6'h0E, 5'd0, 5'd0,  5'd0,  5'd0,  6'h01, 16'h0001, 26'h0000001, 1'b1, 1'b0, 32'h1234567C};
    vecs[5] = '{32'h08100000, 32'hFFFFFFFC, 6'h02, 5'd0, 5'd16, 5'd0,  5'd0,  6'h00, 16'h0000, 26'h0100000, 1'b0, 1'b0, 32'h00000000};
    vecs[6] = '{32'h3C01FFFF, 32'h00000000, 6'h0F, 5'd0, 5'd1,  5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h001FFFF, 1'b0, 1'b0, 32'h00000004};

    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset in_ready",  64'(bus.in_ready),  64'd1);
    check("reset opcode",    64'(bus.opcode),    64'd0);
    check("reset is_rtype",  64'(bus.is_rtype),  64'd1);
    check("reset zero_ext",  64'(bus.zero_ext),  64'd0);
    check("reset pc_plus4",  64'(bus.pc_plus4),  64'd0);

    // Decode table at full throughput.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      offer(1'b1, vecs[i].instr, vecs[i].pc);
      step();
      check($sformatf("v%0d out_valid", i), 64'(bus.out_valid), 64'd1);
      check($sformatf("v%0d in_ready", i),  64'(bus.in_ready),  64'd1);
      check($sformatf("v%0d opcode", i),    64'(bus.opcode),    64'(vecs[i].opcode));
      check($sformatf("v%0d rs", i),        64'(bus.rs),        64'(vecs[i].rs));
      check($sformatf("v%0d rt", i),        64'(bus.rt),        64'(vecs[i].rt));
      check($sformatf("v%0d rd", i),        64'(bus.rd),        64'(vecs[i].rd));
      check($sformatf("v%0d shamt", i),     64'(bus.shamt),     64'(vecs[i].shamt));
      check($sformatf("v%0d funct", i),     64'(bus.funct),     64'(vecs[i].funct));
      check($sformatf("v%0d immediate", i), 64'(bus.immediate), 64'(vecs[i].imm));
      check($sformatf("v%0d target", i),    64'(bus.target),    64'(vecs[i].target));
      check($sformatf("v%0d zero_ext", i),  64'(bus.zero_ext),  64'(vecs[i].zext));
      check($sformatf("v%0d is_rtype", i),  64'(bus.is_rtype),  64'(vecs[i].rtype));
      check($sformatf("v%0d pc_plus4", i),  64'(bus.pc_plus4),  64'(vecs[i].pc4));
    end
    offer(1'b0, 32'h0, 32'h0);
    step();
    check("drain out_valid", 64'(bus.out_valid), 64'd0);

    // Backpressure: A, B absorbed, C held off, then drained in order.
    bus.out_ready = 1'b0;
    offer(1'b1, 32'h8C820004, 32'h00001000);
    step();
    check("bp A out_valid", 64'(bus.out_valid), 64'd1);
    check("bp A instr",     64'(held_instr()),  64'h8C820004);
    check("bp A in_ready",  64'(bus.in_ready),  64'd1);
    check("bp A state",     64'(bus.dbg_state), 64'(SKID_ONE));
    offer(1'b1, 32'hAC820008, 32'h00001004);
    step();
    check("bp B in_ready",  64'(bus.in_ready),  64'd0);
    check("bp B instr",     64'(held_instr()),  64'h8C820004);
    check("bp B pc_plus4",  64'(bus.pc_plus4),  64'h00001004);
    check("bp B state",     64'(bus.dbg_state), 64'(SKID_FULL));
    offer(1'b1, 32'h1000FFFF, 32'h00001008);
    step();
    check("bp C held in_ready", 64'(bus.in_ready), 64'd0);
    check("bp C held instr",    64'(held_instr()), 64'h8C820004);
    bus.out_ready = 1'b1;
    step();
    check("bp out B valid",    64'(bus.out_valid), 64'd1);
    check("bp out B instr",    64'(held_instr()),  64'hAC820008);
    check("bp out B pc_plus4", 64'(bus.pc_plus4),  64'h00001008);
    check("bp out B in_ready", 64'(bus.in_ready),  64'd1);
    step();
    check("bp out C valid",    64'(bus.out_valid), 64'd1);
    check("bp out C instr",    64'(held_instr()),  64'h1000FFFF);
    check("bp out C pc_plus4", 64'(bus.pc_plus4),  64'h0000100C);
    offer(1'b0, 32'h0, 32'h0);
    step();
    check("bp after C valid", 64'(bus.out_valid), 64'd0);

    // Flush with both slots full, input offered and decode consuming.
    bus.out_ready = 1'b0;
    offer(1'b1, 32'h24010001, 32'h00002000);
    step();
    offer(1'b1, 32'h24020002, 32'h00002004);
    step();
    check("fl full in_ready", 64'(bus.in_ready), 64'd0);
    offer(1'b1, 32'h24030003, 32'h00002008);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.flush = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    check("fl out_valid", 64'(bus.out_valid), 64'd0);
    check("fl in_ready",  64'(bus.in_ready),  64'd1);
    check("fl state",     64'(bus.dbg_state), 64'(SKID_EMPTY));
    step();
    check("fl no replay", 64'(bus.out_valid), 64'd0);

    // Flush with only main full while in_ready is high: offer dropped.
    bus.out_ready = 1'b0;
    offer(1'b1, 32'h24040004, 32'h00003000);
    step();
    offer(1'b1, 32'h24050005, 32'h00003004);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    bus.out_ready = 1'b1;
    check("fl1 out_valid", 64'(bus.out_valid), 64'd0);
    step();
    check("fl1 no replay", 64'(bus.out_valid), 64'd0);
    offer(1'b1, 32'h24060006, 32'h00003008);
    step();
    offer(1'b0, 32'h0, 32'h0);
    check("post flush valid", 64'(bus.out_valid), 64'd1);
    check("post flush instr", 64'(held_instr()),  64'h24060006);

    // Asynchronous reset between edges with both slots full.
    bus.out_ready = 1'b0;
    offer(1'b1, 32'h24070007, 32'h00004000);
    step();
    offer(1'b1, 32'h24080008, 32'h00004004);
    step();
    offer(1'b0, 32'h0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst out_valid", 64'(bus.out_valid), 64'd0);
    check("arst in_ready",  64'(bus.in_ready),  64'd1);
    check("arst opcode",    64'(bus.opcode),    64'd0);
    check("arst is_rtype",  64'(bus.is_rtype),  64'd1);
    check("arst zero_ext",  64'(bus.zero_ext),  64'd0);
    check("arst pc_plus4",  64'(bus.pc_plus4),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    check("arst no replay 1", 64'(bus.out_valid), 64'd0);
    step();
    check("arst no replay 2", 64'(bus.out_valid), 64'd0);
    check("arst pc_plus4 hold", 64'(bus.pc_plus4), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
